// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative signed multiply/divide unit for MULT/DIV.
// Radix-2 Booth multiply and restoring divide, one step per cycle, WIDTH
// steps per operation. Owns the HI/LO registers read by MFHI/MFLO.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             HILOWrite,
    output logic             Div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        DONE,
        DIVZ
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               signA_q, signA_d;
    logic               signB_q, signB_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH:0]     boothSum;
    logic [2*WIDTH:0]   boothNext;
    logic [WIDTH:0]     remShift;
    logic               remGeq;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   quoFinal;
    logic [WIDTH-1:0]   remFinal;

    // Datapath for one Booth step, one restoring divide step, and sign fix-up.
    // The Booth partial sum is one bit wider so adding/subtracting the
    // most-negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        absA  = a[WIDTH-1] ? -a : a;
        absB  = b[WIDTH-1] ? -b : b;
        accHi = acc_q[2*WIDTH:WIDTH+1];

        boothSum = {accHi[WIDTH-1], accHi};
        case (acc_q[1:0])
            2'b01:   boothSum = {accHi[WIDTH-1], accHi} + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   boothSum = {accHi[WIDTH-1], accHi} - {opnd_q[WIDTH-1], opnd_q};
            default: boothSum = {accHi[WIDTH-1], accHi};
        endcase
        boothNext = {boothSum, acc_q[WIDTH:1]};

        remShift = {rem_q, quo_q[WIDTH-1]};
        remGeq   = (remShift >= {1'b0, opnd_q});
        remNext  = remGeq ? (remShift[WIDTH-1:0] - opnd_q) : remShift[WIDTH-1:0];
        quoNext  = {quo_q[WIDTH-2:0], remGeq};

        quoFinal = (signA_q ^ signB_q) ? -quoNext : quoNext;
        remFinal = signA_q ? -remNext : remNext;
    end

    // Next-state logic: operand capture in IDLE, stepping in MULT/DIV, and
    // the HI/LO commit on the last step so results appear entering DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        signA_d = signA_q;
        signB_d = signB_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
                    opnd_d  = a;
                    count_d = CNT_LOAD;
                    state_d = MULT;
                end else if (start_div) begin
                    if (b == '0) begin
                        state_d = DIVZ;
                    end else begin
                        quo_d   = absA;
                        opnd_d  = absB;
                        rem_d   = '0;
                        signA_d = a[WIDTH-1];
                        signB_d = b[WIDTH-1];
                        count_d = CNT_LOAD;
                        state_d = DIV;
                    end
                end
            end
            MULT: begin
                acc_d   = boothNext;
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    hi_d    = boothNext[2*WIDTH:WIDTH+1];
                    lo_d    = boothNext[WIDTH:1];
                    state_d = DONE;
                end
            end
            DIV: begin
                rem_d   = remNext;
                quo_d   = quoNext;
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    hi_d    = remFinal;
                    lo_d    = quoFinal;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            DIVZ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            signA_q <= signA_d;
            signB_q <= signB_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign HILOWrite = (state_q == DONE);
    assign Div0      = (state_q == DIVZ);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: scoreboard bench for the multiply/divide sequencer.
module tb_mult_div_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        HILOWrite;
    logic        Div0;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [63:0] hilo;
        logic        isDiv0;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] lastHiLo = '0;
    int          checkCount = 0;
    int          errorCount = 0;
    int          doneCount = 0;
    int          div0Count = 0;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .HILOWrite  (HILOWrite),
        .Div0       (Div0),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Pulse counters so stray or repeated done/Div0 pulses are caught.
    always @(negedge clock) begin
        if (done) doneCount++;
        if (Div0) div0Count++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] modelMult(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    function automatic logic [63:0] modelDiv(input logic [31:0] x, input logic [31:0] y);
        longint q;
        longint r;
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one operation, push its expectation, wait (bounded) for the
    // result, then pop and compare. injectAt>0 pulses start_div mid-flight.
    task automatic applyStimulus(input logic sm, input logic sd, input logic [31:0] aa,
                                 input logic [31:0] bb, input int injectAt);
        exp_t e;
        int   cycles;
        int   busyCycles;
        int   eLat;
        int   d0;
        int   v0;
        if (sm) begin
            e.hilo = modelMult(aa, bb);
            e.isDiv0 = 1'b0;
        end else if (bb == 32'h0) begin
            e.hilo = lastHiLo;
            e.isDiv0 = 1'b1;
        end else begin
            e.hilo = modelDiv(aa, bb);
            e.isDiv0 = 1'b0;
        end
        sb.push_back(e);
        eLat = e.isDiv0 ? 1 : 33;
        d0 = doneCount;
        v0 = div0Count;

        @(negedge clock);
        start_mult = sm;
        start_div  = sd;
        a = aa;
        b = bb;
        @(negedge clock);
        start_mult = 1'b0;
        start_div  = 1'b0;
        cycles = 1;
        busyCycles = 0;
        while (!done && !Div0 && cycles < 60) begin
            if (busy) busyCycles++;
            if (cycles == injectAt) begin
                start_div = 1'b1;
                a = $urandom;
                b = 32'h0;
            end else begin
                start_div = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        start_div = 1'b0;
        if (busy) busyCycles++;

        if (sb.size() > 0) e = sb.pop_front();
        checkOutput("latency", cycles, eLat);
        checkOutput("busyCycles", busyCycles, eLat);
        checkOutput("hilo", {hi, lo}, e.hilo);
        checkOutput("div0Pulse", Div0, e.isDiv0);
        checkOutput("donePulse", done, !e.isDiv0);
        checkOutput("hiloWrite", HILOWrite, !e.isDiv0);

        @(negedge clock);
        #1;
        checkOutput("idleBusy", busy, 0);
        checkOutput("doneCount", doneCount - d0, e.isDiv0 ? 0 : 1);
        checkOutput("div0Count", div0Count - v0, e.isDiv0 ? 1 : 0);
        checkOutput("hiloHold", {hi, lo}, e.hilo);
        lastHiLo = e.hilo;
    endtask

    initial begin
        reset = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        a = '0;
        b = '0;
        #12;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstHiloWrite", HILOWrite, 0);
        checkOutput("rstDiv0", Div0, 0);
        checkOutput("rstHilo", {hi, lo}, 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Multiply sign mix and extremes
        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 0);
        checkOutput("mul7xm3", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        applyStimulus(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0);
        checkOutput("mulMinMin", {hi, lo}, 64'h40000000_00000000);
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        checkOutput("mulM1M1", {hi, lo}, 64'h00000000_00000001);

        // Signed divide
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
        checkOutput("divM7by2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 0);
        checkOutput("div100byM7", {hi, lo}, 64'h00000002_FFFFFFF2);
        applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        checkOutput("divMinByM1", {hi, lo}, 64'h00000000_80000000);
        applyStimulus(1'b0, 1'b1, 32'd0, 32'd9, 0);
        checkOutput("divZeroDividend", {hi, lo}, 64'h0);

        // Divide by zero keeps the preloaded HI/LO
        applyStimulus(1'b1, 1'b0, 32'h00010000, 32'h00120034, 0);
        checkOutput("preload", {hi, lo}, 64'h00000012_00340000);
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, 0);
        checkOutput("div0Hold", {hi, lo}, 64'h00000012_00340000);

        // Ignored starts: mid-flight start_div, and both starts together
        applyStimulus(1'b1, 1'b0, 32'd12345, 32'hFFFF0001, 10);
        applyStimulus(1'b1, 1'b1, 32'd6, 32'd0, 0);
        checkOutput("bothStarts", {hi, lo}, 64'h0);

        // A few random operands through the model
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, $urandom, $urandom, 0);
            applyStimulus(1'b0, 1'b1, $urandom, $urandom | 32'h1, 0);
        end

        // Reset in the middle of a divide
        @(negedge clock);
        start_div = 1'b1;
        a = 32'd1000;
        b = 32'd7;
        @(negedge clock);
        start_div = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clock);
        checkOutput("midBusy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortDiv0", Div0, 0);
        checkOutput("abortHilo", {hi, lo}, 64'h0);
        lastHiLo = '0;
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd5, 0);
        checkOutput("mul3x5", {hi, lo}, 64'h00000000_0000000F);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
